// File: rtl/seg_serial_out.sv
// Serialises a 64-bit 7-segment image MSB-first into cascaded 74HC595 registers, then pulses the storage latch.
// Latency: 129*CLK_DIV cycles from the start edge to done; busy falls one cycle later.
// Backpressure: start is ignored while busy. The optional SEG_AUTO_REFRESH_EN re-sends every REFRESH_CYC cycles.
module seg_serial_out #(
    parameter int CLK_DIV     = 2,
    parameter int REFRESH_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] SEG_TXT,
    output logic        busy,
    output logic        done,
    output logic        seg_clk,
    output logic        seg_dat,
    output logic        seg_en,
    output logic        seg_clr_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] PH_MID  = 9'(CLK_DIV - 1);
    localparam logic [8:0] PH_LAST = 9'(2 * CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255 || REFRESH_CYC < 1) begin : g_illegal_cfg
        $error("seg_serial_out: CLK_DIV must be 1..255 and REFRESH_CYC >= 1");
    end

    state_t      state_q, state_d;
    logic [63:0] shreg_q, shreg_d;
    logic [8:0]  phase_q, phase_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        seg_clk_q, seg_clk_d;
    logic        seg_dat_q, seg_dat_d;
    logic        seg_en_q, seg_en_d;
    logic        seg_clr_n_q, seg_clr_n_d;
    logic        start_req;
    logic        load;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic          pend_q, pend_d;
    logic          ref_wrap;

    always_comb begin
        ref_wrap  = (ref_cnt_q == RW'(REFRESH_CYC - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        // A wrap landing on the load edge counts as a fresh request.
        pend_d    = (pend_q & ~load) | ref_wrap;
        start_req = start | pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            pend_q    <= pend_d;
        end
    end
`else
    always_comb begin
        start_req = start;
    end
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        seg_clk_d   = seg_clk_q;
        seg_dat_d   = seg_dat_q;
        seg_en_d    = seg_en_q;
        seg_clr_n_d = 1'b1;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    load      = 1'b1;
                    state_d   = SHIFT;
                    shreg_d   = SEG_TXT;
                    busy_d    = 1'b1;
                    seg_dat_d = SEG_TXT[63];
                    seg_clk_d = 1'b0;
                    phase_d   = '0;
                    bit_cnt_d = 6'd63;
                end
            end

            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    seg_clk_d = 1'b0;
                    phase_d   = '0;
                    if (bit_cnt_q == 6'd0) begin
                        seg_en_d = 1'b1;
                        state_d  = LATCH;
                    end else begin
                        // Rotate rather than shift so every register bit stays live.
                        shreg_d   = {shreg_q[62:0], shreg_q[63]};
                        seg_dat_d = shreg_q[62];
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end else begin
                    phase_d = phase_q + 9'd1;
                    if (phase_q == PH_MID) begin
                        seg_clk_d = 1'b1;
                    end
                end
            end

            LATCH: begin
                if (phase_q == PH_MID) begin
                    seg_en_d = 1'b0;
                    done_d   = 1'b1;
                    phase_d  = '0;
                    state_d  = DONE;
                end else begin
                    phase_d = phase_q + 9'd1;
                end
            end

            DONE: begin
                done_d    = 1'b0;
                busy_d    = 1'b0;
                seg_dat_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_clk_q   <= 1'b0;
            seg_dat_q   <= 1'b0;
            seg_en_q    <= 1'b0;
            seg_clr_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seg_clk_q   <= seg_clk_d;
            seg_dat_q   <= seg_dat_d;
            seg_en_q    <= seg_en_d;
            seg_clr_n_q <= seg_clr_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign seg_clk   = seg_clk_q;
    assign seg_dat   = seg_dat_q;
    assign seg_en    = seg_en_q;
    assign seg_clr_n = seg_clr_n_q;

endmodule

// File: doc/seg_serial_out.md
Name: seg_serial_out

Overview:
- Downstream stage of the hex-to-7-segment encoder.
- Takes the encoder's 64-bit segment image (8 digits x 8 segment bits) and shifts it serially, MSB first, into the board's cascaded 74HC595-style segment shift registers.
- Pulses the storage latch after the last bit so all eight digits update in one step.
- Output-pin timing is generated from the system clock through a programmable divider.

Parameters:
- CLK_DIV, 2: system-clock cycles per seg_clk half-period; legal range 1..255.
- REFRESH_CYC, 50000: cycles between automatic re-sends. Used only with SEG_AUTO_REFRESH_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one transfer; sampled only in IDLE.
- SEG_TXT  input  64  segment image from the encoder; bit 63 is sent first, bit 0 last.
- busy  output  1  high from the load edge until return to IDLE.
- done  output  1  one-cycle pulse when the latch phase completes.
- seg_clk  output  1  shift clock to the external registers.
- seg_dat  output  1  serial data; valid and stable for the whole bit period.
- seg_en  output  1  storage-latch pulse, active high.
- seg_clr_n  output  1  external shift-register clear, active low.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, seg_clk=0, seg_dat=0, seg_en=0, seg_clr_n=0, state=IDLE, counters=0.
- seg_clr_n rises to 1 on the first clk edge after rst_n deasserts and then stays 1.
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE: start=1 sampled at edge k gives, at that edge:
  - state=SHIFT, shift register=SEG_TXT, busy=1;
  - seg_dat=SEG_TXT[63], seg_clk=0, phase=0, bit_cnt=63.
- SHIFT:
  - Phase counter counts 0..2*CLK_DIV-1.
  - seg_clk goes to 1 when phase reaches CLK_DIV, i.e. CLK_DIV cycles after the data change, so the rising edge is mid-bit.
  - At the end of the period, seg_clk returns to 0 and the shift register shifts left; seg_dat takes the next bit and bit_cnt decrements.
  - After bit 0's period, at edge k+128*CLK_DIV: seg_clk=0, seg_en=1, state=LATCH.
- LATCH: seg_en is held high for CLK_DIV cycles. At edge k+129*CLK_DIV: seg_en=0, done=1, state=DONE.
- DONE: at the next edge, done=0, busy=0, seg_dat=0, state=IDLE.
- Latency from the start-sampling edge to done: 129*CLK_DIV cycles. With CLK_DIV=2 this is 258.
- Back-to-back requests: start is accepted again on the first IDLE cycle, so back-to-back transfers have one idle cycle between them.
- Per transfer: exactly 64 seg_clk rising edges and exactly one seg_en pulse.
- SEG_TXT is captured only at load. Changes during a transfer do not affect the current transfer.
- start while busy is ignored; it is neither queued nor an error.
- Reset mid-transfer:
  - Immediate abort to the reset values. No seg_en pulse, so the external display keeps its previously latched image.
  - seg_clr_n=0 clears the partially shifted data.
- Counter widths: phase is 9 bits; bit_cnt is 6 bits and does not wrap past 0.

Optional Feature:
SEG_AUTO_REFRESH_EN
- Defined:
  - A free-running refresh counter runs from reset over 0..REFRESH_CYC-1 and wraps. At wrap it sets a pending flag.
  - In IDLE, pending=1 acts as start; the flag clears at the load edge.
  - A wrap while busy keeps the flag set and is consumed at the next IDLE.
  - External start still works. start and pending in the same IDLE cycle produce one transfer and clear the flag.
  - Reset clears both counter and flag.
- Undefined: no refresh counter and no flag; transfers come only from start, and REFRESH_CYC has no effect.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> all outputs 0; seg_clr_n goes to 1 one edge after release; busy stays 0 with start=0.
- Single transfer, CLK_DIV=2, SEG_TXT=64'hC0F9A4B0_999282F8, start pulsed 1 cycle -> 64 seg_clk rising edges; the bench reconstructs the word by sampling seg_dat at each rising edge and gets 64'hC0F9A4B0_999282F8; seg_en high for 2 cycles; done exactly 258 cycles after the start edge; busy low one cycle later.
- Ignored start and input change: pulse start at cycles 10 and 100 of a transfer, and change SEG_TXT to 64'hFFFFFFFF_FFFFFFFF mid-transfer -> still one transfer with the original data; a single done.
- Reset mid-transfer: assert rst_n=0 after 20 seg_clk edges -> seg_en never pulses, seg_clr_n=0, busy=0; a fresh transfer afterwards is correct.
- Boundary patterns and divider extremes: CLK_DIV=1 with SEG_TXT=64'h80000000_00000001, then 64'h0 -> first and last serial bits are 1 and all others 0 for the first word; all 0 for the second; done latency 129 cycles.
- SEG_AUTO_REFRESH_EN defined, REFRESH_CYC=400, CLK_DIV=2 -> a transfer starts every 400 cycles without start. With REFRESH_CYC=100, a wrap during busy gives a transfer starting 1 cycle after busy falls.
